// File: rtl/ysyx_24090013_rf_wb_sched_if.sv
// Issue, write-back and register-file write bundle for the write-back scheduler.
// The scheduler takes the slave modport; decode, execute units and register file sit on master.
interface ysyx_24090013_rf_wb_sched_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  iss_valid;
  logic                  iss_rs1_en;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic                  iss_rs2_en;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic                  iss_rd_en;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_stall;

  logic                  alu_wb_valid;
  logic [ADDR_WIDTH-1:0] alu_wb_addr;
  logic [DATA_WIDTH-1:0] alu_wb_data;
  logic                  alu_wb_ready;

  logic                  lsu_wb_valid;
  logic [ADDR_WIDTH-1:0] lsu_wb_addr;
  logic [DATA_WIDTH-1:0] lsu_wb_data;
  logic                  lsu_wb_ready;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH:0]   busy_cnt;
  logic                  err_spurious_wb;

  modport slave (
    input  iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    output iss_stall,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    output alu_wb_ready,
    input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    output lsu_wb_ready,
    output rf_wen, rf_waddr, rf_wdata, busy_cnt, err_spurious_wb
  );

  modport master (
    output iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    input  iss_stall,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  alu_wb_ready,
    output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    input  lsu_wb_ready,
    input  rf_wen, rf_waddr, rf_wdata, busy_cnt, err_spurious_wb
  );
endinterface

// File: rtl/ysyx_24090013_rf_wb_sched.sv
// Write-back scheduler and busy-bit scoreboard for the integer register file:
// round-robin ALU/LSU arbitration onto one registered write port plus RAW/WAW issue stall.
module ysyx_24090013_rf_wb_sched #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_24090013_rf_wb_sched_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  localparam logic [0:0] LAST_ALU = 1'b0;
  localparam logic [0:0] LAST_LSU = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [NREG-1:0]       BUSY_MASK  = {{(NREG-1){1'b1}}, 1'b0};

  function automatic logic [ADDR_WIDTH:0] f_popcount(input logic [NREG-1:0] v);
    logic [ADDR_WIDTH:0] n;
    n = {(ADDR_WIDTH+1){1'b0}};
    for (int k = 0; k < NREG; k++) begin
      n = n + {{ADDR_WIDTH{1'b0}}, v[k]};
    end
    return n;
  endfunction

  function automatic logic [NREG-1:0] f_onehot(input logic en, input logic [ADDR_WIDTH-1:0] idx);
    logic [NREG-1:0] v;
    v      = {NREG{1'b0}};
    v[idx] = en;
    return v;
  endfunction

  logic [NREG-1:0]       r_busy;
  logic [ADDR_WIDTH:0]   r_busy_cnt;
  logic [0:0]            r_last;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic                  r_err;

  logic                  w_rs1_hit;
  logic                  w_rs2_hit;
  logic                  w_rd_hit;
  logic                  w_stall;
  logic                  w_fire;
  logic                  w_gnt_alu;
  logic                  w_gnt_lsu;
  logic                  w_gnt_any;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_wr_take;
  logic                  w_spurious;
  logic                  w_set_en;
  logic [NREG-1:0]       w_set_mask;
  logic [NREG-1:0]       w_clr_mask;
  logic [NREG-1:0]       w_busy_nxt;

  // Hazard check against the busy bits.
  always_comb begin
    w_rs1_hit = bus.iss_rs1_en & r_busy[bus.iss_rs1];
    w_rs2_hit = bus.iss_rs2_en & r_busy[bus.iss_rs2];
    w_rd_hit  = bus.iss_rd_en  & r_busy[bus.iss_rd];
    w_stall   = bus.iss_valid & (w_rs1_hit | w_rs2_hit | w_rd_hit);
    w_fire    = bus.iss_valid & ~w_stall;
  end

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    case ({bus.alu_wb_valid, bus.lsu_wb_valid})
      2'b10: w_gnt_alu = 1'b1;
      2'b01: w_gnt_lsu = 1'b1;
      2'b11: begin
        if (r_last == LAST_LSU) begin
          w_gnt_alu = 1'b1;
        end else begin
          w_gnt_lsu = 1'b1;
        end
      end
      default: begin
        w_gnt_alu = 1'b0;
        w_gnt_lsu = 1'b0;
      end
    endcase
  end

  // Granted write-back mux and spurious-write detection.
  always_comb begin
    w_gnt_any = w_gnt_alu | w_gnt_lsu;
    if (w_gnt_alu) begin
      w_gnt_addr = bus.alu_wb_addr;
      w_gnt_data = bus.alu_wb_data;
    end else begin
      w_gnt_addr = bus.lsu_wb_addr;
      w_gnt_data = bus.lsu_wb_data;
    end
    w_wr_take  = w_gnt_any & (w_gnt_addr != ADDR_ZERO);
    w_spurious = w_wr_take & ~r_busy[w_gnt_addr];
  end

  // Next busy vector: the retiring write clears, a fresh issue sets, and set wins.
  always_comb begin
    w_set_en   = w_fire & bus.iss_rd_en & (bus.iss_rd != ADDR_ZERO);
    w_set_mask = f_onehot(w_set_en, bus.iss_rd);
    w_clr_mask = f_onehot(r_rf_wen, r_rf_waddr);
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & BUSY_MASK;
  end

  // Scoreboard bits and their population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= {NREG{1'b0}};
      r_busy_cnt <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= f_popcount(w_busy_nxt);
    end
  end

  // Arbitration pointer moves only when something is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_LSU;
    end else if (w_gnt_alu) begin
      r_last <= LAST_ALU;
    end else if (w_gnt_lsu) begin
      r_last <= LAST_LSU;
    end else begin
      r_last <= r_last;
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= ADDR_ZERO;
      r_rf_wdata <= {DATA_WIDTH{1'b0}};
    end else if (w_wr_take) begin
      r_rf_wen   <= 1'b1;
      r_rf_waddr <= w_gnt_addr;
      r_rf_wdata <= w_gnt_data;
    end else begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= r_rf_waddr;
      r_rf_wdata <= r_rf_wdata;
    end
  end

  // Sticky flag for a write-back that no issued instruction was waiting on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_spurious;
    end
  end

  assign bus.iss_stall       = w_stall;
  assign bus.alu_wb_ready    = w_gnt_alu;
  assign bus.lsu_wb_ready    = w_gnt_lsu;
  assign bus.rf_wen          = r_rf_wen;
  assign bus.rf_waddr        = r_rf_waddr;
  assign bus.rf_wdata        = r_rf_wdata;
  assign bus.busy_cnt        = r_busy_cnt;
  assign bus.err_spurious_wb = r_err;
endmodule

// File: tb/tb_ysyx_24090013_rf_wb_sched.sv
// Directed scenarios followed by randomized traffic, all checked against a behavioural
// scoreboard model (busy set, last-granted requester, pending register write).
module tb_ysyx_24090013_rf_wb_sched;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_24090013_rf_wb_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_24090013_rf_wb_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // reference model state
  bit          m_busy [NR];
  int          m_last;      // 0: ALU granted last, 1: LSU granted last
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;

  // per-cycle results for directed checks
  bit g_alu, g_lsu;
  bit o_stall, o_ardy, o_lrdy;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int k = 0; k < NR; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  function automatic logic [4:0] pick_addr();
    int s;
    s = int'($urandom_range(NR - 1, 0));
    if ($urandom_range(9, 0) != 0) begin
      for (int k = 0; k < NR; k++) begin
        if (m_busy[(s + k) % NR]) return 5'((s + k) % NR);
      end
    end
    return 5'(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
    m_last  = 1;
    m_wen   = 1'b0;
    m_waddr = 0;
    m_wdata = 32'h0;
    m_err   = 1'b0;
  endtask

  task automatic set_iss(input bit v, input bit e1, input int r1, input bit e2, input int r2,
                         input bit ed, input int rd);
    bus.iss_valid  = v;
    bus.iss_rs1_en = e1;
    bus.iss_rs1    = 5'(r1);
    bus.iss_rs2_en = e2;
    bus.iss_rs2    = 5'(r2);
    bus.iss_rd_en  = ed;
    bus.iss_rd     = 5'(rd);
  endtask

  task automatic set_alu(input bit v, input int a, input logic [31:0] d);
    bus.alu_wb_valid = v;
    bus.alu_wb_addr  = 5'(a);
    bus.alu_wb_data  = d;
  endtask

  task automatic set_lsu(input bit v, input int a, input logic [31:0] d);
    bus.lsu_wb_valid = v;
    bus.lsu_wb_addr  = 5'(a);
    bus.lsu_wb_data  = d;
  endtask

  task automatic idle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    set_alu(1'b0, 0, 32'h0);
    set_lsu(1'b0, 0, 32'h0);
  endtask

  // Entered at posedge+1 with inputs applied; checks all outputs, then advances the model one edge.
  task automatic cycle();
    bit st, ga, gl, any, set_rd;
    int gaddr, rd;
    logic [31:0] gdata;
    st = bus.iss_valid && ((bus.iss_rs1_en && m_busy[bus.iss_rs1]) ||
                           (bus.iss_rs2_en && m_busy[bus.iss_rs2]) ||
                           (bus.iss_rd_en  && m_busy[bus.iss_rd]));
    if (bus.alu_wb_valid && bus.lsu_wb_valid) begin
      ga = (m_last == 1);
      gl = !ga;
    end else begin
      ga = bus.alu_wb_valid;
      gl = bus.lsu_wb_valid;
    end
    any    = ga || gl;
    gaddr  = ga ? int'(bus.alu_wb_addr) : int'(bus.lsu_wb_addr);
    gdata  = ga ? bus.alu_wb_data : bus.lsu_wb_data;
    rd     = int'(bus.iss_rd);
    set_rd = !st && bus.iss_valid && bus.iss_rd_en && rd != 0;
    #3;
    o_stall = bus.iss_stall;
    o_ardy  = bus.alu_wb_ready;
    o_lrdy  = bus.lsu_wb_ready;
    chk("iss_stall", 64'(o_stall), 64'(st));
    chk("alu_wb_ready", 64'(o_ardy), 64'(ga));
    chk("lsu_wb_ready", 64'(o_lrdy), 64'(gl));
    chk("rf_wen", 64'(bus.rf_wen), 64'(m_wen));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
    chk("busy_cnt", 64'(bus.busy_cnt), 64'(busy_count()));
    chk("err_spurious_wb", 64'(bus.err_spurious_wb), 64'(m_err));
    g_alu = ga;
    g_lsu = gl;
    @(posedge clk);
    if (any && gaddr != 0 && !m_busy[gaddr]) m_err = 1'b1;
    if (m_wen) m_busy[m_waddr] = 1'b0;
    if (set_rd) m_busy[rd] = 1'b1;
    if (any && gaddr != 0) begin
      m_wen   = 1'b1;
      m_waddr = gaddr;
      m_wdata = gdata;
    end else begin
      m_wen = 1'b0;
    end
    if (ga) m_last = 0;
    else if (gl) m_last = 1;
    #1;
  endtask

  task automatic issue_rd(input int rd);
    set_iss(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, rd);
    cycle();
    set_iss(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    bit a_p, l_p;
    logic [4:0] a_a, l_a;
    logic [31:0] a_d, l_d;
    int ai, li;

    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("reset_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("reset_err", 64'(bus.err_spurious_wb), 64'd0);
    rst_n = 1'b1;
    cycle();

    // contention right after reset: ALU first, then LSU
    issue_rd(3);
    issue_rd(4);
    set_alu(1'b1, 3, 32'h11);
    set_lsu(1'b1, 4, 32'h22);
    cycle();
    chk("t3_first_alu", 64'(o_ardy), 64'd1);
    chk("t3_first_lsu", 64'(o_lrdy), 64'd0);
    set_alu(1'b0, 0, 32'h0);
    chk("t3_wr1_addr", 64'(bus.rf_waddr), 64'd3);
    chk("t3_wr1_data", 64'(bus.rf_wdata), 64'h11);
    cycle();
    chk("t3_second_lsu", 64'(o_lrdy), 64'd1);
    set_lsu(1'b0, 0, 32'h0);
    chk("t3_wr2_wen", 64'(bus.rf_wen), 64'd1);
    chk("t3_wr2_addr", 64'(bus.rf_waddr), 64'd4);
    chk("t3_wr2_data", 64'(bus.rf_wdata), 64'h22);
    cycle();

    // continuous contention with fresh targets alternates A,L,A,L,A,L
    for (int k = 10; k < 16; k++) issue_rd(k);
    ai = 0;
    li = 0;
    for (int k = 0; k < 6; k++) begin
      set_alu(1'b1, 10 + 2 * ai, $urandom);
      set_lsu(1'b1, 11 + 2 * li, $urandom);
      cycle();
      chk("t4_alternate", 64'(o_ardy), 64'((k % 2) == 0));
      if (g_alu) ai++;
      if (g_lsu) li++;
    end
    idle();
    repeat (2) cycle();
    chk("t4_drained", 64'(bus.busy_cnt), 64'd0);

    // basic issue / write-back / clear
    issue_rd(5);
    chk("t1_busy_cnt_set", 64'(bus.busy_cnt), 64'd1);
    set_alu(1'b1, 5, 32'hDEADBEEF);
    cycle();
    chk("t1_alu_ready", 64'(o_ardy), 64'd1);
    set_alu(1'b0, 0, 32'h0);
    chk("t1_rf_wen", 64'(bus.rf_wen), 64'd1);
    chk("t1_rf_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("t1_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    cycle();
    chk("t1_busy_cnt_clr", 64'(bus.busy_cnt), 64'd0);

    // RAW and WAW stall on register 7
    issue_rd(7);
    set_iss(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 0);
    cycle();
    chk("t2_raw_stall", 64'(o_stall), 64'd1);
    set_iss(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 7);
    cycle();
    chk("t2_waw_stall", 64'(o_stall), 64'd1);
    set_iss(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 0);
    set_alu(1'b1, 7, 32'h77);
    cycle();
    chk("t2_stall_grant", 64'(o_stall), 64'd1);
    set_alu(1'b0, 0, 32'h0);
    cycle();
    chk("t2_stall_wen", 64'(o_stall), 64'd1);
    cycle();
    chk("t2_release", 64'(o_stall), 64'd0);
    idle();

    // write-back to x0 dropped; spurious write flagged and sticky
    set_lsu(1'b1, 0, 32'h55);
    cycle();
    chk("t5_x0_ready", 64'(o_lrdy), 64'd1);
    set_lsu(1'b0, 0, 32'h0);
    chk("t5_x0_no_wen", 64'(bus.rf_wen), 64'd0);
    chk("t5_x0_no_err", 64'(bus.err_spurious_wb), 64'd0);
    set_alu(1'b1, 9, 32'h99);
    cycle();
    set_alu(1'b0, 0, 32'h0);
    chk("t5_err_set", 64'(bus.err_spurious_wb), 64'd1);
    chk("t5_wr9_addr", 64'(bus.rf_waddr), 64'd9);
    cycle();
    chk("t5_err_sticky", 64'(bus.err_spurious_wb), 64'd1);

    // reset while a write is in flight with three registers busy
    for (int k = 20; k < 24; k++) issue_rd(k);
    set_alu(1'b1, 20, 32'hA0);
    cycle();
    set_alu(1'b0, 0, 32'h0);
    set_lsu(1'b1, 21, 32'hA1);
    cycle();
    set_lsu(1'b0, 0, 32'h0);
    chk("t6_pre_wen", 64'(bus.rf_wen), 64'd1);
    chk("t6_pre_cnt", 64'(bus.busy_cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wen", 64'(bus.rf_wen), 64'd0);
    chk("t6_rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("t6_rst_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("t6_rst_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("t6_rst_err", 64'(bus.err_spurious_wb), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("t6_no_stale_write", 64'(bus.rf_wen), 64'd0);
    issue_rd(1);
    issue_rd(2);
    set_alu(1'b1, 1, 32'hB1);
    set_lsu(1'b1, 2, 32'hB2);
    cycle();
    chk("t6_alu_first", 64'(o_ardy), 64'd1);
    set_alu(1'b0, 0, 32'h0);
    cycle();
    idle();
    cycle();

    // randomized traffic honouring the hold-until-ready rule
    a_p = 1'b0;
    l_p = 1'b0;
    a_a = 5'd0;
    l_a = 5'd0;
    a_d = 32'h0;
    l_d = 32'h0;
    for (int n = 0; n < 600; n++) begin
      if (!a_p && $urandom_range(1, 0) == 1) begin
        a_p = 1'b1;
        a_a = pick_addr();
        a_d = $urandom;
      end
      if (!l_p && $urandom_range(2, 0) == 0) begin
        l_p = 1'b1;
        l_a = pick_addr();
        l_d = $urandom;
      end
      set_alu(a_p, int'(a_a), a_d);
      set_lsu(l_p, int'(l_a), l_d);
      set_iss($urandom_range(2, 0) != 0, 1'($urandom), int'($urandom_range(NR - 1, 0)),
              1'($urandom), int'($urandom_range(NR - 1, 0)),
              1'($urandom), int'($urandom_range(NR - 1, 0)));
      cycle();
      if (g_alu) a_p = 1'b0;
      if (g_lsu) l_p = 1'b0;
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_24090013_rf_wb_sched.md
Name: ysyx_24090013_rf_wb_sched

Overview:
Write-back scheduler and scoreboard for the 32x32 integer register file (one write port, two read ports).
- Shares the single write port between two write-back requesters, ALU and LSU, using round-robin arbitration.
- Drives a registered write to the register file.
- Tracks per-register pending-write (busy) bits and stalls issue on RAW/WAW hazards.
- Sits between decode/issue, the execute units and the register file.

Parameters:
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
DATA_WIDTH, 32, write data width.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
iss_valid  input  1  decode presents an instruction
iss_rs1_en  input  1  instruction reads rs1
iss_rs1  input  ADDR_WIDTH  rs1 index
iss_rs2_en  input  1  instruction reads rs2
iss_rs2  input  ADDR_WIDTH  rs2 index
iss_rd_en  input  1  instruction writes rd
iss_rd  input  ADDR_WIDTH  rd index
iss_stall  output  1  hazard; issue must hold (combinational)
alu_wb_valid  input  1  ALU result available
alu_wb_addr  input  ADDR_WIDTH  ALU destination
alu_wb_data  input  DATA_WIDTH  ALU result
alu_wb_ready  output  1  ALU result accepted this cycle
lsu_wb_valid  input  1  load result available
lsu_wb_addr  input  ADDR_WIDTH  load destination
lsu_wb_data  input  DATA_WIDTH  load result
lsu_wb_ready  output  1  load result accepted this cycle
rf_wen  output  1  register file write enable
rf_waddr  output  ADDR_WIDTH  register file write address
rf_wdata  output  DATA_WIDTH  register file write data
busy_cnt  output  ADDR_WIDTH+1  number of registers with pending writes
err_spurious_wb  output  1  sticky: write-back to a non-busy register

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits=0, busy_cnt=0, err_spurious_wb=0.
  - Round-robin pointer = last grant LSU, so ALU wins the first contention.
  - Reset mid-operation discards any in-flight write; nothing is written after rst_n deasserts until a new grant.
- Hazard check, combinational:
  - iss_stall = iss_valid & ((iss_rs1_en & busy[iss_rs1]) | (iss_rs2_en & busy[iss_rs2]) | (iss_rd_en & busy[iss_rd])).
  - busy[0] is always 0.
  - iss_fire = iss_valid & ~iss_stall.
- Scoreboard set: on iss_fire with iss_rd_en and iss_rd!=0, busy[iss_rd] is set at the next edge.
- Arbitration, combinational grant, at most one per cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins; the pointer updates only on a grant.
  - ready = grant. A requester holds valid/addr/data stable until ready.
- Write stage, 1-cycle latency:
  - On a grant with addr!=0: at the next edge rf_wen<=1, rf_waddr<=addr, rf_wdata<=data.
  - Otherwise rf_wen<=0; rf_waddr and rf_wdata hold.
  - A grant with addr=0 is accepted (ready=1) and dropped; no write, no busy change.
- Scoreboard clear:
  - At an edge where rf_wen=1, busy[rf_waddr] is cleared; this is the same edge at which the register file captures the data.
  - Issue in the following cycle therefore reads the new value with no bypass needed.
- Simultaneous set and clear of the same index at one edge: set wins. This only occurs on a legal re-issue after the stall releases.
- Spurious write: at the grant cycle, if the granted addr!=0 and busy[addr]=0, err_spurious_wb is set sticky until reset. The write still proceeds.
- busy_cnt: registered popcount of the busy bits, updated at the same edge as the bits; range 0..2**ADDR_WIDTH-1.
- Throughput: one write-back per cycle sustained. The losing requester waits at most one cycle under continuous contention.

Test Plan:
1. Issue rd=5 → busy_cnt=1. ALU wb addr 5, data 0xDEADBEEF → alu_wb_ready=1 that cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle busy_cnt=0.
2. busy[7]=1, issue rs1=7 → iss_stall=1 until the cycle after rf_wen for 7, then 0. Issue rd=7 while busy → stall (WAW).
3. Rd 3 and 4 busy, ALU(3, 0x11) and LSU(4, 0x22) valid together for 2 cycles → ALU granted first, then LSU. rf writes 3/0x11 then 4/0x22 on consecutive cycles.
4. Continuous contention over 6 cycles, both valid with fresh busy targets each → grants alternate A,L,A,L,A,L.
5. LSU wb addr 0, data 0x55 → lsu_wb_ready=1, rf_wen stays 0, err_spurious_wb stays 0. ALU wb to non-busy reg 9 → err_spurious_wb=1 and stays 1; rf writes 9.
6. rst_n low for 1 cycle while rf_wen=1 and busy_cnt=3 → outputs immediately 0, busy_cnt=0. The first post-reset contention grants ALU.
